ofdm_frame_scheduler: RTL and testbench

Frame-level sequencer for the 64-QAM OFDM loopback chain: encoder, QAM mapper, FFT/IFFT core, output reorder, quantiser, de-mapper and Viterbi decoder. It buffers incoming 192-bit payloads in a small FIFO and walks each frame through the chain with one-cycle start pulses and done handshakes. Per-stage watchdogs catch hung stages, and the decoded word is returned on a valid/ready output port. It sits above the datapath instances and replaces ad-hoc flag chaining with a single explicit FSM.

---
 rtl/ofdm_frame_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_ofdm_frame_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_scheduler.sv
// ofdm_frame_scheduler
// Frame-level sequencer for the 64-QAM OFDM loopback chain. Incoming payloads
// are buffered in a small FIFO. Each frame is then walked through encoder ->
// FFT -> reorder -> quantiser -> decoder using one-cycle start/capture strobes
// and done handshakes. The decoded word is returned on a valid/ready port.
//
// Ports
//   clk, reset             clock (rising edge), async active-low reset
//   in_valid/in_data       payload offered to the input FIFO
//   in_ready               FIFO not full
//   out_valid/out_data     decoded frame, held until out_ready
//   out_ready              consumer accepts the decoded frame
//   enc_data               working payload, stable from ENC entry to next pop
//   enc/fft/dec_start      one-cycle start pulses to the datapath stages
//   enc/fft/dec_done       stage completion (level or pulse)
//   dec_result             decoder output word
//   cap_fft, cap_deqam     one-cycle capture strobes for reorder / de-mapper
//   err_clr, err_timeout   watchdog error clear / sticky error flag
//   busy                   controller active or frames queued
//   frame_cnt              frames delivered (wraps)
//   stage                  current state encoding
//
// State | meaning
//   IDLE  0 | waiting for a queued frame; pops the FIFO head on exit
//   ENC   1 | encoder running, waiting for enc_done (watchdog active)
//   FFT   2 | FFT/IFFT running, waiting for fft_done (watchdog active)
//   REORD 3 | single cycle, cap_fft loads the reorder register
//   QUANT 4 | single cycle, cap_deqam loads the de-mapper registers
//   DEC   5 | decoder running, waiting for dec_done (watchdog active)
//   OUT   6 | decoded frame presented, waiting for out_ready
//   ERR   7 | watchdog expired, frame dropped, waiting for err_clr
module ofdm_frame_scheduler #(
  parameter int DATA_W     = 192,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] enc_data,
  output logic              enc_start,
  output logic              fft_start,
  output logic              dec_start,
  input  logic              enc_done,
  input  logic              fft_done,
  input  logic              dec_done,
  input  logic [DATA_W-1:0] dec_result,
  output logic              cap_fft,
  output logic              cap_deqam,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [2:0]        stage
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENC   = 3'd1,
    S_FFT   = 3'd2,
    S_REORD = 3'd3,
    S_QUANT = 3'd4,
    S_DEC   = 3'd5,
    S_OUT   = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------------------
  // Input frame FIFO (power-of-two depth, pointers wrap naturally)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, fifo_nempty;

  assign fifo_nempty = (count != '0);
  assign in_ready    = (count != FULL_CNT);
  assign push        = in_valid && in_ready;
  assign pop         = (state == S_IDLE) && fifo_nempty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [WW-1:0] wd, wd_n;
  logic          wd_hit;
  logic          enc_start_n, fft_start_n, dec_start_n;
  logic          cap_fft_n, cap_deqam_n;
  logic          out_valid_n, err_timeout_n, load_out;
  logic [15:0]   frame_cnt_n;

  assign wd_hit = (wd == WD_LIMIT);

  // A start strobe is high exactly in the first cycle of its wait state, so it
  // doubles as the "ignore done this cycle" qualifier. wd_n defaults to zero,
  // which clears the watchdog on every state change and in unwatched states;
  // done is therefore watched for exactly TIMEOUT cycles after the start cycle.
  always_comb begin
    state_n       = state;
    wd_n          = '0;
    enc_start_n   = 1'b0;
    fft_start_n   = 1'b0;
    dec_start_n   = 1'b0;
    cap_fft_n     = 1'b0;
    cap_deqam_n   = 1'b0;
    out_valid_n   = out_valid;
    err_timeout_n = err_timeout;
    frame_cnt_n   = frame_cnt;
    load_out      = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_nempty) begin
          state_n     = S_ENC;
          enc_start_n = 1'b1;
        end
      end
      S_ENC: begin
        if (enc_done && !enc_start) begin
          state_n     = S_FFT;
          fft_start_n = 1'b1;
        end else if (wd_hit) begin
          state_n       = S_ERR;
          err_timeout_n = 1'b1;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      S_FFT: begin
        if (fft_done && !fft_start) begin
          state_n   = S_REORD;
          cap_fft_n = 1'b1;
        end else if (wd_hit) begin
          state_n       = S_ERR;
          err_timeout_n = 1'b1;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      S_REORD: begin
        state_n     = S_QUANT;
        cap_deqam_n = 1'b1;
      end
      S_QUANT: begin
        state_n     = S_DEC;
        dec_start_n = 1'b1;
      end
      S_DEC: begin
        if (dec_done && !dec_start) begin
          state_n     = S_OUT;
          out_valid_n = 1'b1;
          load_out    = 1'b1;
        end else if (wd_hit) begin
          state_n       = S_ERR;
          err_timeout_n = 1'b1;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
          frame_cnt_n = frame_cnt + 16'd1;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_n       = S_IDLE;
          err_timeout_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wd          <= '0;
      enc_start   <= 1'b0;
      fft_start   <= 1'b0;
      dec_start   <= 1'b0;
      cap_fft     <= 1'b0;
      cap_deqam   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      enc_data    <= '0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      wd          <= wd_n;
      enc_start   <= enc_start_n;
      fft_start   <= fft_start_n;
      dec_start   <= dec_start_n;
      cap_fft     <= cap_fft_n;
      cap_deqam   <= cap_deqam_n;
      out_valid   <= out_valid_n;
      err_timeout <= err_timeout_n;
      frame_cnt   <= frame_cnt_n;
      if (pop)      enc_data <= mem[rd_ptr];
      if (load_out) out_data <= dec_result;
    end
  end

  assign stage = state;
  assign busy  = (state != S_IDLE) || fifo_nempty;

endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
module tb_ofdm_frame_scheduler;
  localparam int DW = 192;
  localparam int TO = 1023;
  localparam logic [DW-1:0] MASK = {24{8'h3C}};
  localparam logic [DW-1:0] PAT_A5 = {24{8'hA5}};

  logic          clk, reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data, enc_data, dec_result;
  logic          enc_start, fft_start, dec_start;
  logic          enc_done, fft_done, dec_done;
  logic          cap_fft, cap_deqam, err_clr, err_timeout, busy;
  logic [15:0]   frame_cnt;
  logic [2:0]    stage;

  int n_checks = 0;
  int n_fail = 0;

  // stage model controls
  int enc_delay = 5, fft_delay = 5, dec_delay = 5;
  bit fft_hold = 0, enc_force = 0;
  int enc_cnt, fft_cnt, dec_cnt;

  // monitors
  int n_enc, n_fft, n_dec, n_capf, n_capd, n_strobe_bad;
  logic [DW-1:0] got_q[$];

  ofdm_frame_scheduler #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .enc_data(enc_data), .enc_start(enc_start), .fft_start(fft_start),
    .dec_start(dec_start), .enc_done(enc_done), .fft_done(fft_done),
    .dec_done(dec_done), .dec_result(dec_result), .cap_fft(cap_fft),
    .cap_deqam(cap_deqam), .err_clr(err_clr), .err_timeout(err_timeout),
    .busy(busy), .frame_cnt(frame_cnt), .stage(stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage models: done pulses for one cycle, delay cycles after the start cycle.
  initial begin
    enc_cnt = 0; enc_done = 0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin enc_cnt = 0; enc_done = 0; end
      else begin
        enc_done = enc_force;
        if (enc_start) enc_cnt = enc_delay;
        else if (enc_cnt > 0) begin
          enc_cnt--;
          if (enc_cnt == 0) enc_done = 1'b1;
        end
      end
    end
  end

  initial begin
    fft_cnt = 0; fft_done = 0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin fft_cnt = 0; fft_done = 0; end
      else begin
        fft_done = 1'b0;
        if (fft_start) fft_cnt = fft_delay;
        else if (fft_cnt > 0) begin
          fft_cnt--;
          if (fft_cnt == 0 && !fft_hold) fft_done = 1'b1;
        end
      end
    end
  end

  // Decoder returns the working payload XOR a fixed mask.
  initial begin
    dec_cnt = 0; dec_done = 0; dec_result = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin dec_cnt = 0; dec_done = 0; end
      else begin
        dec_done = 1'b0;
        if (dec_start) dec_cnt = dec_delay;
        else if (dec_cnt > 0) begin
          dec_cnt--;
          if (dec_cnt == 0) begin
            dec_done = 1'b1;
            dec_result = enc_data ^ MASK;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #2;
      if (enc_start) n_enc++;
      if (fft_start) n_fft++;
      if (dec_start) n_dec++;
      if (cap_fft) begin n_capf++; if (stage != 3'd3) n_strobe_bad++; end
      if (cap_deqam) begin n_capd++; if (stage != 3'd4) n_strobe_bad++; end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic clear_mon();
    n_enc = 0; n_fft = 0; n_dec = 0; n_capf = 0; n_capd = 0; n_strobe_bad = 0;
    got_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
    enc_delay = 5; fft_delay = 5; dec_delay = 5; fft_hold = 0; enc_force = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input int budget, output bit ok);
    int i;
    for (i = 0; i < budget && frame_cnt != 16'(target); i++) @(negedge clk);
    ok = (frame_cnt == 16'(target));
  endtask

  task automatic wait_stage(input logic [2:0] s, input int budget, output bit ok);
    int i;
    for (i = 0; i < budget && stage != s; i++) @(negedge clk);
    ok = (stage == s);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_busy: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || enc_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got out_valid=%b out_data=%h enc_data=%h, want zeros", out_valid, out_data, enc_data);
    end
    n_checks++;
    if ({enc_start, fft_start, dec_start, cap_fft, cap_deqam} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000", {enc_start, fft_start, dec_start, cap_fft, cap_deqam});
    end
    n_checks++;
    if (err_timeout !== 1'b0 || frame_cnt !== 16'd0 || stage !== 3'd0) begin
      n_fail++; $display("FAIL reset_status: got err=%b cnt=%0d stage=%0d, want 0 0 0", err_timeout, frame_cnt, stage);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    apply_reset();
    push_frame(PAT_A5 ^ MASK);
    n_checks++;
    if (stage !== 3'd0 || enc_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_after_push: got stage=%0d enc_start=%b busy=%b, want 0 0 1", stage, enc_start, busy);
    end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd1 || enc_start !== 1'b1 || enc_data !== (PAT_A5 ^ MASK)) begin
      n_fail++; $display("FAIL single_pop: got stage=%0d enc_start=%b enc_data=%h, want 1 1 %h", stage, enc_start, enc_data, PAT_A5 ^ MASK);
    end
    wait_cnt(1, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_wait: frame_cnt=%0d, want 1 within budget", frame_cnt); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_enc != 1 || n_fft != 1 || n_dec != 1 || n_capf != 1 || n_capd != 1) begin
      n_fail++; $display("FAIL single_pulses: got enc=%0d fft=%0d dec=%0d capf=%0d capd=%0d, want all 1", n_enc, n_fft, n_dec, n_capf, n_capd);
    end
    n_checks++;
    if (n_strobe_bad != 0) begin n_fail++; $display("FAIL single_strobe_stage: %0d capture strobes outside REORD/QUANT, want 0", n_strobe_bad); end
    n_checks++;
    if (got_q.size() != 1 || out_data !== PAT_A5) begin
      n_fail++; $display("FAIL single_out_data: got n=%0d out_data=%h, want 1 %h", got_q.size(), out_data, PAT_A5);
    end
    n_checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || out_valid !== 1'b0 || stage !== 3'd0) begin
      n_fail++; $display("FAIL single_end: got cnt=%0d busy=%b out_valid=%b stage=%0d, want 1 0 0 0", frame_cnt, busy, out_valid, stage);
    end
  endtask

  task automatic test_first_cycle_done();
    bit ok;
    apply_reset();
    enc_force = 1;
    push_frame(192'h1234);
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd1 || enc_start !== 1'b1) begin
      n_fail++; $display("FAIL first_cycle_entry: got stage=%0d enc_start=%b, want 1 1", stage, enc_start);
    end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd1) begin n_fail++; $display("FAIL first_cycle_ignore: got stage=%0d, want 1", stage); end
    @(negedge clk);
    enc_force = 0;
    n_checks++;
    if (stage !== 3'd2 || fft_start !== 1'b1) begin
      n_fail++; $display("FAIL first_cycle_accept: got stage=%0d fft_start=%b, want 2 1", stage, fft_start);
    end
    wait_cnt(1, 100, ok);
    n_checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== (192'h1234 ^ MASK)) begin
      n_fail++; $display("FAIL first_cycle_result: cnt=%0d n=%0d, want 1 1", frame_cnt, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] frames[5];
    logic [31:0] w;
    bit ok;
    apply_reset();
    enc_delay = 30;
    for (int i = 0; i < 5; i++) begin
      w = 32'hF00D_0000 + 32'(i);
      frames[i] = {6{w}};
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before_push%0d: got 0, want 1", i); end
      push_frame(frames[i]);
    end
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || stage !== 3'd1) begin
      n_fail++; $display("FAIL b2b_full: got in_ready=%b busy=%b stage=%0d, want 0 1 1", in_ready, busy, stage);
    end
    enc_delay = 5;
    wait_cnt(5, 1000, ok);
    n_checks++;
    if (!ok || got_q.size() != 5) begin
      n_fail++; $display("FAIL b2b_count: cnt=%0d delivered=%0d, want 5 5", frame_cnt, got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== (frames[i] ^ MASK)) begin
        n_fail++; $display("FAIL b2b_order%0d: got %h want %h", i, got_q[i], frames[i] ^ MASK);
      end
    end
    n_checks++;
    if (n_enc != 5 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end: enc_starts=%0d in_ready=%b, want 5 1", n_enc, in_ready);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [DW-1:0] fa, fb, fc;
    fa = 192'hAAAA_0001; fb = 192'hBBBB_0002; fc = 192'hCCCC_0003;
    apply_reset();
    fft_hold = 1;
    push_frame(fa);
    push_frame(fb);
    wait_stage(3'd2, 50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_reach_fft: stage=%0d, want 2", stage); end
    repeat (TO) @(negedge clk);
    n_checks++;
    if (stage !== 3'd2 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_last_wait: got stage=%0d err=%b, want 2 0", stage, err_timeout);
    end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd7 || err_timeout !== 1'b1) begin
      n_fail++; $display("FAIL to_err: got stage=%0d err=%b, want 7 1", stage, err_timeout);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL to_err_ready: got 0, want 1"); end
    push_frame(fc);
    repeat (5) @(negedge clk);
    n_checks++;
    if (stage !== 3'd7 || err_timeout !== 1'b1 || n_enc != 1 || n_fft != 1 || n_dec != 0) begin
      n_fail++; $display("FAIL to_err_hold: stage=%0d err=%b enc=%0d fft=%0d dec=%0d, want 7 1 1 1 0", stage, err_timeout, n_enc, n_fft, n_dec);
    end
    fft_hold = 0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (stage !== 3'd0 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_clear: got stage=%0d err=%b, want 0 0", stage, err_timeout);
    end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd1 || enc_data !== fb) begin
      n_fail++; $display("FAIL to_next_pop: got stage=%0d enc_data=%h, want 1 %h", stage, enc_data, fb);
    end
    wait_cnt(2, 300, ok);
    n_checks++;
    if (!ok || got_q.size() != 2) begin
      n_fail++; $display("FAIL to_deliver: cnt=%0d n=%0d, want 2 2", frame_cnt, got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== (fb ^ MASK) || got_q[1] !== (fc ^ MASK)) begin
        n_fail++; $display("FAIL to_order: got %h %h", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    bit ok;
    apply_reset();
    fft_delay = TO;
    push_frame(192'h5EED);
    wait_stage(3'd2, 50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tb_reach_fft: stage=%0d, want 2", stage); end
    repeat (TO) @(negedge clk);
    n_checks++;
    if (stage !== 3'd2) begin n_fail++; $display("FAIL tb_last_wait: got stage=%0d, want 2", stage); end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd3 || cap_fft !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL tb_done_wins: got stage=%0d cap_fft=%b err=%b, want 3 1 0", stage, cap_fft, err_timeout);
    end
    wait_cnt(1, 100, ok);
    n_checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== (192'h5EED ^ MASK)) begin
      n_fail++; $display("FAIL tb_deliver: cnt=%0d n=%0d, want 1 1", frame_cnt, got_q.size());
    end
  endtask

  task automatic test_out_stall();
    bit ok;
    int i;
    logic [DW-1:0] fp, fq;
    fp = {3{64'h0123_4567_89AB_CDEF}}; fq = {3{64'hFEDC_BA98_7654_3210}};
    apply_reset();
    out_ready = 1'b0;
    push_frame(fp);
    push_frame(fq);
    for (i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== (fp ^ MASK) || stage !== 3'd6) begin
      n_fail++; $display("FAIL stall_present: got valid=%b data=%h stage=%0d", out_valid, out_data, stage);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== (fp ^ MASK) || stage !== 3'd6 || n_enc != 1 || frame_cnt !== 16'd0) begin
        n_fail++; $display("FAIL stall_hold%0d: valid=%b stage=%0d enc=%0d cnt=%0d, want 1 6 1 0", c, out_valid, stage, n_enc, frame_cnt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 16'd1 || stage !== 3'd0) begin
      n_fail++; $display("FAIL stall_release: got valid=%b cnt=%0d stage=%0d, want 0 1 0", out_valid, frame_cnt, stage);
    end
    @(negedge clk);
    n_checks++;
    if (stage !== 3'd1 || enc_data !== fq) begin
      n_fail++; $display("FAIL stall_next_pop: got stage=%0d enc_data=%h, want 1 %h", stage, enc_data, fq);
    end
    wait_cnt(2, 100, ok);
    n_checks++;
    if (!ok || got_q.size() != 2 || got_q[0] !== (fp ^ MASK) || got_q[1] !== (fq ^ MASK)) begin
      n_fail++; $display("FAIL stall_deliver: cnt=%0d n=%0d, want 2 2", frame_cnt, got_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    dec_delay = 40;
    push_frame(192'hD1);
    push_frame(192'hD2);
    push_frame(192'hD3);
    wait_stage(3'd5, 100, ok);
    n_checks++;
    if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL rst_reach_dec: stage=%0d busy=%b, want 5 1", stage, busy); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (stage !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'd0 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_status: stage=%0d busy=%b ready=%b cnt=%0d err=%b, want 0 0 1 0 0", stage, busy, in_ready, frame_cnt, err_timeout);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || enc_data !== '0 || {enc_start, fft_start, dec_start, cap_fft, cap_deqam} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: valid=%b out_data=%h enc_data=%h", out_valid, out_data, enc_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dec_delay = 5;
    clear_mon();
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_enc != 0 || n_dec != 0 || stage !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_resume: enc=%0d dec=%0d stage=%0d busy=%b, want 0 0 0 0", n_enc, n_dec, stage, busy);
    end
    push_frame(192'hD4);
    wait_cnt(1, 100, ok);
    n_checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== (192'hD4 ^ MASK)) begin
      n_fail++; $display("FAIL rst_new_frame: cnt=%0d n=%0d, want 1 1", frame_cnt, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_first_cycle_done();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_out_stall();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
